// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: strobes one row per slot, classifies each
// four-row frame and debounces single-key presses/releases into a key code.
module key_matrix_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [3:0]       col_p0, col_p1;
  logic [DIV_W-1:0] div;
  logic [1:0]       ri;
  logic [1:0]       ri_nxt;
  logic             tick;
  logic             frame_done;
  logic [1:0]       acc_n;
  logic [3:0]       acc_key;
  logic [2:0]       smp_n;
  logic [2:0]       tot;
  logic [1:0]       frm_n;
  logic [3:0]       frm_key;
  logic             is_none, is_single, is_match;
  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [3:0]       cnt_inc;
  logic [3:0]       cand;

  function automatic logic [2:0] low_count(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, ~c[i]};
    return n;
  endfunction

  function automatic logic [1:0] low_pos(input logic [3:0] c);
    logic [1:0] p;
    p = 2'd0;
    for (int i = 3; i >= 0; i--) if (!c[i]) p = 2'(i);
    return p;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous columns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= col;
      col_p1 <= col_p0;
    end
  end

  assign tick       = (div == DIV_MAX);
  assign ri_nxt     = ri + 2'd1;
  assign frame_done = tick && (ri == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      ri  <= 2'd0;
      row <= 4'b1110;
    end else if (tick) begin
      div <= '0;
      ri  <= ri_nxt;
      row <= ~(4'b0001 << ri_nxt);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Low-bit count saturates at 2: anything beyond one low bit is MULTI
  assign smp_n     = low_count(col_p1);
  assign tot       = {1'b0, acc_n} + smp_n;
  assign frm_n     = (tot >= 3'd2) ? 2'd2 : tot[1:0];
  assign frm_key   = (acc_n == 2'd0) ? {ri, low_pos(col_p1)} : acc_key;
  assign is_none   = (frm_n == 2'd0);
  assign is_single = (frm_n == 2'd1);
  assign is_match  = is_single && (frm_key == cand);
  assign cnt_inc   = cnt + 4'd1;

  // Stage p2: per-frame accumulation of the sampled row results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n   <= 2'd0;
      acc_key <= 4'd0;
    end else if (tick) begin
      if (ri == 2'd3) begin
        acc_n   <= 2'd0;
        acc_key <= 4'd0;
      end else begin
        acc_n   <= frm_n;
        acc_key <= frm_key;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          S_IDLE: begin
            if (is_single) begin
              cand <= frm_key;
              cnt  <= 4'd1;
              if (DEB_N == 4'd1) begin
                state     <= S_PRESSED;
                key_code  <= frm_key;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end else begin
                state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (is_match) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_N) begin
                state     <= S_PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end
            end else begin
              state <= S_IDLE;
              cnt   <= 4'd0;
            end
          end
          S_PRESSED: begin
            // Any key activity while held, including a second key, is ignored
            if (is_none) begin
              cnt <= 4'd1;
              if (DEB_N == 4'd1) begin
                state    <= S_IDLE;
                key_down <= 1'b0;
              end else begin
                state <= S_RELEASE;
              end
            end
          end
          default: begin
            if (is_none) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_N) begin
                state    <= S_IDLE;
                key_down <= 1'b0;
              end
            end else begin
              state <= S_PRESSED;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Scoreboard bench for key_matrix_scan: a matrix model drives col from row and
// a pressed-key mask; expectations are queued and checked by a monitor.
module tb_key_matrix_scan;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = 16'h0000;

  key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r]) col = col & ~pressed[r*4 +: 4];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; logic [3:0] val; } chk_t;
  typedef struct { int cyc; logic [3:0] code; } pulse_t;
  chk_t   chk_q[$];
  pulse_t exp_q[$];
  pulse_t e;
  int     checks = 0;
  int     errors = 0;
  bit     done = 1'b0;
  bit     fin = 1'b0;
  int     R;

  function automatic logic [3:0] probe(int kind);
    case (kind)
      0:       return row;
      1:       return {3'b000, key_down};
      default: return key_code;
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0:       return "row";
      1:       return "key_down";
      default: return "key_code";
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      checks++;
      if (row !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
        errors++;
        $display("FAIL reset_values cyc=%0d: row=%b code=%0d valid=%b down=%b, want row=1110 code=0 valid=0 down=0",
                 cyc, row, key_code, key_valid, key_down);
      end
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == cyc) begin
        checks++;
        if (probe(chk_q[i].kind) !== chk_q[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d: got %b, want %b", kname(chk_q[i].kind), cyc,
                   probe(chk_q[i].kind), chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse cyc=%0d: no key_valid, want code=%0d at cyc=%0d", cyc, exp_q[0].code, exp_q[0].cyc);
      exp_q.delete(0);
    end
    if (rst_n && key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d: key_valid=1 code=%0d, want no pulse", cyc, key_code);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.code !== key_code) begin
          errors++;
          $display("FAIL pulse: got code=%0d at cyc=%0d, want code=%0d at cyc=%0d", key_code, cyc, e.code, e.cyc);
        end
      end
    end
    if (done && !fin) begin
      checks++;
      if (exp_q.size() != 0 || chk_q.size() != 0) begin
        errors++;
        $display("FAIL pending: %0d pulses and %0d checks left, want 0 and 0", exp_q.size(), chk_q.size());
      end
      fin = 1'b1;
    end
  end

  task automatic expect_sig(int off, int kind, logic [3:0] val);
    chk_t c;
    c.cyc  = cyc + off;
    c.kind = kind;
    c.val  = val;
    chk_q.push_back(c);
  endtask

  task automatic expect_pulse(int off, logic [3:0] code);
    pulse_t p;
    p.cyc  = cyc + off;
    p.code = code;
    exp_q.push_back(p);
  endtask

  task automatic frames(int n);
    repeat (FR * n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Power-on reset with no key pressed
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    R = cyc;
    expect_sig(1, 0, 4'b1110);
    expect_sig(4, 0, 4'b1101);
    expect_sig(8, 0, 4'b1011);
    expect_sig(12, 0, 4'b0111);
    expect_sig(16, 0, 4'b1110);
    expect_sig(16, 1, 4'd0);
    expect_sig(16, 2, 4'd0);
    repeat (FR) @(posedge clk);
    #1;

    // Clean press of key 6, then hold for 5 more frames
    pressed = 16'h0040;
    expect_sig(47, 1, 4'd0);
    expect_pulse(48, 4'd6);
    expect_sig(48, 1, 4'd1);
    expect_sig(48, 2, 4'd6);
    frames(3);
    expect_sig(5 * FR, 1, 4'd1);
    expect_sig(5 * FR, 2, 4'd6);
    frames(5);
    pressed = 16'h0000;
    expect_sig(47, 1, 4'd1);
    expect_sig(48, 1, 4'd0);
    frames(3);

    // Bounce: 2 frames present, 1 absent, 3 present
    pressed = 16'h0040;
    expect_sig(32, 1, 4'd0);
    expect_pulse(96, 4'd6);
    frames(2);
    pressed = 16'h0000;
    frames(1);
    pressed = 16'h0040;
    frames(3);
    pressed = 16'h0000;
    expect_sig(48, 1, 4'd0);
    frames(3);

    // Release glitch: 2 NONE, 1 restore, 3 NONE
    pressed = 16'h0040;
    expect_pulse(48, 4'd6);
    frames(3);
    pressed = 16'h0000;
    expect_sig(32, 1, 4'd1);
    frames(2);
    pressed = 16'h0040;
    expect_sig(16, 1, 4'd1);
    frames(1);
    pressed = 16'h0000;
    expect_sig(32, 1, 4'd1);
    expect_sig(47, 1, 4'd1);
    expect_sig(48, 1, 4'd0);
    frames(3);

    // Ghosting: keys 0 and 5 together
    pressed = 16'h0021;
    expect_sig(80, 1, 4'd0);
    expect_sig(80, 2, 4'd6);
    frames(5);
    pressed = 16'h0000;
    frames(1);

    // Reset in the middle of debouncing key 15
    pressed = 16'h8000;
    frames(2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    expect_sig(1, 0, 4'b1110);
    expect_sig(32, 1, 4'd0);
    expect_sig(47, 1, 4'd0);
    expect_pulse(48, 4'd15);
    expect_sig(48, 1, 4'd1);
    expect_sig(48, 2, 4'd15);
    repeat (3 * FR) @(posedge clk);
    repeat (4) @(posedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
